// File: rtl/biquad8_coeff_loader.sv
// Wishbone master that streams a latched set of 19 biquad8 coefficients (plus an
// optional update strobe) into a biquad8_wrapper_v2 slave, one write at a time.
module biquad8_coeff_loader #(
   parameter int NCOEF     = 19,
   parameter int TIMEOUT   = 255,
   parameter bit DO_UPDATE = 1'b1
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic                 start_i,
   input  logic [NCOEF*18-1:0]  coeff_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic [4:0]           err_idx_o,
   output logic                 wb_cyc_o,
   output logic                 wb_stb_o,
   output logic                 wb_we_o,
   output logic [6:0]           wb_adr_o,
   output logic [31:0]          wb_dat_o,
   output logic [3:0]           wb_sel_o,
   input  logic                 wb_ack_i,
   input  logic                 wb_err_i
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;

   localparam logic [4:0] LAST_IDX = DO_UPDATE ? 5'd19 : 5'd18;
   localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

   logic [1:0]           state_r;
   logic [4:0]           idx_r;
   logic [7:0]           to_cnt_r;
   logic [NCOEF*18-1:0]  coeff_r;
   logic                 busy_r;
   logic                 done_r;
   logic                 err_r;
   logic [4:0]           err_idx_r;
   logic                 cyc_r;
   logic [6:0]           adr_r;
   logic [31:0]          dat_r;

   // Slave register address for each step of the programming sequence.
   function automatic logic [6:0] wr_addr(input logic [4:0] idx);
      logic [6:0] a;
      if (idx <= 5'd1) begin
         a = 7'h04;
      end else if (idx <= 5'd4) begin
         a = 7'h10;
      end else if (idx <= 5'd8) begin
         a = 7'h14;
      end else if (idx == 5'd9) begin
         a = 7'h18;
      end else if (idx == 5'd10) begin
         a = 7'h1C;
      end else if (idx <= 5'd14) begin
         a = 7'h08;
      end else if (idx <= 5'd18) begin
         a = 7'h0C;
      end else begin
         a = 7'h00;
      end
      return a;
   endfunction

   // Coefficient writes carry the raw 18-bit field; the step past them is the update strobe.
   function automatic logic [31:0] wr_data(input logic [4:0] idx,
                                           input logic [NCOEF*18-1:0] coeffs);
      logic [31:0] d;
      int unsigned base;
      base = 18 * int'(idx);
      if (idx < 5'(NCOEF)) begin
         d = {14'b0, coeffs[base +: 18]};
      end else begin
         d = 32'h0000_0001;
      end
      return d;
   endfunction

   // Sequencer: launches each write, waits for ack/err/timeout, inserts one idle gap.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_r   <= ST_IDLE;
         idx_r     <= 5'd0;
         to_cnt_r  <= 8'd0;
         coeff_r   <= '0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         err_r     <= 1'b0;
         err_idx_r <= 5'd0;
         cyc_r     <= 1'b0;
         adr_r     <= 7'h00;
         dat_r     <= 32'h0000_0000;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start_i) begin
                  coeff_r   <= coeff_i;
                  err_r     <= 1'b0;
                  err_idx_r <= 5'd0;
                  idx_r     <= 5'd0;
                  to_cnt_r  <= 8'd0;
                  busy_r    <= 1'b1;
                  cyc_r     <= 1'b1;
                  adr_r     <= wr_addr(5'd0);
                  dat_r     <= wr_data(5'd0, coeff_i);
                  state_r   <= ST_WRITE;
               end else begin
                  state_r   <= ST_IDLE;
               end
            end
            ST_WRITE: begin
               // A bus error wins over an ack arriving in the same cycle.
               if (wb_err_i || (!wb_ack_i && (to_cnt_r == TO_LAST))) begin
                  cyc_r     <= 1'b0;
                  busy_r    <= 1'b0;
                  err_r     <= 1'b1;
                  err_idx_r <= idx_r;
                  state_r   <= ST_IDLE;
               end else if (wb_ack_i) begin
                  cyc_r <= 1'b0;
                  if (idx_r == LAST_IDX) begin
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                     state_r <= ST_IDLE;
                  end else begin
                     idx_r   <= idx_r + 5'd1;
                     state_r <= ST_GAP;
                  end
               end else begin
                  to_cnt_r <= to_cnt_r + 8'd1;
               end
            end
            ST_GAP: begin
               cyc_r    <= 1'b1;
               to_cnt_r <= 8'd0;
               adr_r    <= wr_addr(idx_r);
               dat_r    <= wr_data(idx_r, coeff_r);
               state_r  <= ST_WRITE;
            end
            default: begin
               cyc_r   <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy_o    = busy_r;
   assign done_o    = done_r;
   assign err_o     = err_r;
   assign err_idx_o = err_idx_r;
   assign wb_cyc_o  = cyc_r;
   assign wb_stb_o  = cyc_r;
   assign wb_we_o   = cyc_r;
   assign wb_adr_o  = adr_r;
   assign wb_dat_o  = dat_r;
   assign wb_sel_o  = 4'hF;

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// Self-checking bench for biquad8_coeff_loader: a behavioural Wishbone slave with
// programmable delay/fault injection, checked against the sequence table model.
`timescale 1ns/1ps
module tb_biquad8_coeff_loader;

   localparam int NCOEF = 19;
   localparam int TO    = 16;
   localparam int NV    = 10;

   logic                clk = 1'b0;
   logic                rst;
   logic                start;
   logic [NCOEF*18-1:0] coeff;
   logic                busy, done_o, err_o;
   logic [4:0]          err_idx;
   logic                cyc, stb, we;
   logic [6:0]          adr;
   logic [31:0]         dat;
   logic [3:0]          sel;
   logic                ack, err_i;

   always #5 clk = ~clk;

   biquad8_coeff_loader #(.NCOEF(NCOEF), .TIMEOUT(TO), .DO_UPDATE(1'b1)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .coeff_i(coeff),
      .busy_o(busy), .done_o(done_o), .err_o(err_o), .err_idx_o(err_idx),
      .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_adr_o(adr),
      .wb_dat_o(dat), .wb_sel_o(sel), .wb_ack_i(ack), .wb_err_i(err_i)
   );

   typedef struct {
      string name;
      int    dmode;      // -1: random 0..10 ack delay, else fixed delay
      int    err_at;     // write index answered with err+ack (-1 none)
      int    noack_at;   // write index never acked (-1 none)
      bit    disturb;    // start pulses, coeff churn, stray acks in gaps
      bit    exp_done;
      bit    exp_err;
      int    exp_writes;
      int    exp_err_idx;
   } vec_t;

   vec_t vecs [NV];

   localparam logic [6:0] ADR_TAB [20] = '{
      7'h04, 7'h04, 7'h10, 7'h10, 7'h10, 7'h14, 7'h14, 7'h14, 7'h14, 7'h18,
      7'h1C, 7'h08, 7'h08, 7'h08, 7'h08, 7'h0C, 7'h0C, 7'h0C, 7'h0C, 7'h00};

   int          checks   = 0;
   int          failures = 0;
   logic [17:0] cf [NCOEF];
   logic [6:0]  cap_adr [20];
   logic [31:0] cap_dat [20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_dat(input int k);
      if (k < NCOEF) return {14'b0, cf[k]};
      else return 32'h0000_0001;
   endfunction

   task automatic load_coeffs();
      for (int k = 0; k < NCOEF; k++) coeff[18*k +: 18] = cf[k];
   endtask

   task automatic run_seq(input string tag, input int dmode, input int err_at, input int noack_at,
                          input bit disturb, input int rst_at,
                          output int nwr, output int ndone, output int done_cyc, output int exp_lat);
      int n, widx, hi, waitc, dly, last_drop, bad, post_cyc;
      bit inw, fin;
      logic [6:0]  a0;
      logic [31:0] d0;
      n = 0; widx = 0; hi = 0; waitc = 0; dly = 0; last_drop = 0; bad = 0; post_cyc = 0;
      inw = 1'b0; fin = 1'b0; a0 = 7'h00; d0 = 32'h0;
      ndone = 0; done_cyc = 0; exp_lat = 40; nwr = 0;
      @(negedge clk);
      load_coeffs();
      start = 1'b1;
      @(negedge clk);
      n = 1;
      while (!fin) begin
         if (n == 1) begin
            check({tag, "_busy_at_t1"}, 32'(busy), 32'd1);
            check({tag, "_err_clear_at_t1"}, 32'(err_o), 32'd0);
         end
         if (stb !== cyc || we !== cyc || sel !== 4'hF) bad++;
         if (done_o) begin ndone++; done_cyc = n; end
         if (cyc) begin
            if (!inw) begin
               inw = 1'b1; hi = 0; waitc = 0;
               dly = (dmode < 0) ? int'($urandom_range(0, 10)) : dmode;
               exp_lat += dly;
               a0 = adr; d0 = dat;
               if (widx < 20) begin
                  cap_adr[widx] = adr; cap_dat[widx] = dat;
                  check($sformatf("%s_w%0d_adr", tag, widx), 32'(adr), 32'(ADR_TAB[widx]));
                  check($sformatf("%s_w%0d_dat", tag, widx), dat, exp_dat(widx));
               end
               if (widx > 0) check($sformatf("%s_gap%0d", tag, widx), 32'(n - last_drop), 32'd1);
            end else if (adr !== a0 || dat !== d0) begin
               bad++;
            end
            hi++;
            if (rst_at == widx && hi == 2) begin
               rst = 1'b1;
               #1;
               check({tag, "_rst_cyc"}, 32'(cyc), 32'd0);
               check({tag, "_rst_busy"}, 32'(busy), 32'd0);
               check({tag, "_rst_done_err"}, 32'({done_o, err_o}), 32'd0);
               @(negedge clk);
               rst = 1'b0; start = 1'b0; ack = 1'b0; err_i = 1'b0;
               nwr = widx;
               return;
            end
            if (widx == err_at) begin
               ack = 1'b1; err_i = 1'b1;
            end else if (widx == noack_at) begin
               ack = 1'b0; err_i = 1'b0;
            end else if (waitc >= dly) begin
               ack = 1'b1; err_i = 1'b0;
            end else begin
               ack = 1'b0; err_i = 1'b0; waitc++;
            end
         end else begin
            err_i = 1'b0;
            ack = disturb ? 1'($urandom_range(0, 1)) : 1'b0;
            if (inw) begin
               inw = 1'b0;
               if (widx == noack_at) check({tag, "_timeout_len"}, 32'(hi), 32'(TO));
               widx++;
               last_drop = n;
            end
         end
         if (disturb) begin
            start = 1'($urandom_range(0, 1));
            for (int k = 0; k < NCOEF; k++) coeff[18*k +: 18] = 18'($urandom);
         end else begin
            start = 1'b0;
         end
         if (!busy) begin
            fin = 1'b1; start = 1'b0; ack = 1'b0; err_i = 1'b0;
         end else if (n >= 3000) begin
            failures++;
            $display("FAIL %s_cycle_budget busy still high after %0d cycles", tag, n);
            fin = 1'b1; start = 1'b0; ack = 1'b0; err_i = 1'b0;
         end
         if (!fin) begin
            @(negedge clk);
            n++;
         end
      end
      repeat (4) begin
         @(negedge clk);
         if (cyc) post_cyc++;
         if (done_o) ndone++;
      end
      check({tag, "_bus_stable"}, 32'(bad), 32'd0);
      check({tag, "_idle_after"}, 32'(post_cyc), 32'd0);
      nwr = widx;
   endtask

   initial begin
      int nwr, ndone, done_cyc, exp_lat;
      vecs[0] = '{"ack0",    0, -1, -1, 1'b0, 1'b1, 1'b0, 20, 0};
      vecs[1] = '{"rand",   -1, -1, -1, 1'b0, 1'b1, 1'b0, 20, 0};
      vecs[2] = '{"noack7",  0, -1,  7, 1'b0, 1'b0, 1'b1,  8, 7};
      vecs[3] = '{"disturb",-1, -1, -1, 1'b1, 1'b1, 1'b0, 20, 0};
      vecs[4] = '{"err12",  -1, 12, -1, 1'b0, 1'b0, 1'b1, 13, 12};
      vecs[5] = '{"rand2",  -1, -1, -1, 1'b1, 1'b1, 1'b0, 20, 0};
      vecs[6] = '{"err0",    0,  0, -1, 1'b0, 1'b0, 1'b1,  1, 0};
      vecs[7] = '{"noack0",  2, -1,  0, 1'b0, 1'b0, 1'b1,  1, 0};
      vecs[8] = '{"err19",   0, 19, -1, 1'b0, 1'b0, 1'b1, 20, 19};
      vecs[9] = '{"noack19",-1, -1, 19, 1'b1, 1'b0, 1'b1, 20, 19};

      rst = 1'b1; start = 1'b0; coeff = '0; ack = 1'b0; err_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_ctrl", 32'({busy, done_o, err_o, cyc, stb, we}), 32'd0);
      check("reset_err_idx", 32'(err_idx), 32'd0);
      check("reset_adr", 32'(adr), 32'd0);
      check("reset_dat", dat, 32'd0);
      check("reset_sel", 32'(sel), 32'hF);

      for (int v = 0; v < NV; v++) begin
         for (int k = 0; k < NCOEF; k++) cf[k] = 18'($urandom);
         if (v == 0) begin cf[0] = 18'h3FDAF; cf[1] = 18'h0375A; end
         run_seq(vecs[v].name, vecs[v].dmode, vecs[v].err_at, vecs[v].noack_at,
                 vecs[v].disturb, -1, nwr, ndone, done_cyc, exp_lat);
         check({vecs[v].name, "_writes"}, 32'(nwr), 32'(vecs[v].exp_writes));
         check({vecs[v].name, "_done_count"}, 32'(ndone), 32'(vecs[v].exp_done));
         check({vecs[v].name, "_err"}, 32'(err_o), 32'(vecs[v].exp_err));
         if (vecs[v].exp_err) check({vecs[v].name, "_err_idx"}, 32'(err_idx), 32'(vecs[v].exp_err_idx));
         if (vecs[v].exp_done) check({vecs[v].name, "_latency"}, 32'(done_cyc), 32'(exp_lat));
         if (v == 0) begin
            check("ack0_first_adr", 32'(cap_adr[0]), 32'h04);
            check("ack0_first_dat", cap_dat[0], 32'h0003FDAF);
            check("ack0_last_adr", 32'(cap_adr[19]), 32'h00);
            check("ack0_last_dat", cap_dat[19], 32'h00000001);
            check("ack0_done_at_40", 32'(done_cyc), 32'd40);
         end
      end

      // Reset in the middle of write 5, then a clean restart from index 0.
      for (int k = 0; k < NCOEF; k++) cf[k] = 18'($urandom);
      run_seq("rst5", 3, -1, -1, 1'b0, 5, nwr, ndone, done_cyc, exp_lat);
      check("rst5_writes_reached", 32'(nwr), 32'd5);
      check("rst5_after_ctrl", 32'({busy, done_o, err_o, cyc}), 32'd0);
      for (int k = 0; k < NCOEF; k++) cf[k] = 18'($urandom);
      run_seq("restart", -1, -1, -1, 1'b0, -1, nwr, ndone, done_cyc, exp_lat);
      check("restart_writes", 32'(nwr), 32'd20);
      check("restart_done", 32'(ndone), 32'd1);
      check("restart_err", 32'(err_o), 32'd0);
      check("restart_latency", 32'(done_cyc), 32'(exp_lat));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
